// File: rtl/rv32i_instr_encoder.sv
// rv32i_instr_encoder
//   Turns an RV32I encode request into a 32-bit instruction word and emits it
//   with its target word address over a single-stage output register.
//
//   Handshakes: a transfer happens on a rising clk edge where valid && ready.
//   valid must not depend on ready; once m_valid is high, m_addr/m_data stay
//   stable until the transfer. s_ready is 1 when the output is empty, or when
//   the held word drains in the same cycle.
//
// Ports
//   clk, rst_n                 clock, asynchronous active-low reset
//   s_valid / s_ready          request handshake
//   s_mnemonic [5:0]           instruction code (table below)
//   s_rs1/s_rs2/s_rd [4:0]     register operands
//   s_imm [31:0]               signed immediate, or shift amount
//   base_load, base_addr       load a new write pointer (honoured only when empty)
//   m_valid/m_ready            output word handshake
//   m_addr, m_data             word address and encoded instruction
//   err_illegal                one-cycle pulse after a rejected request
//   word_cnt, illegal_cnt      saturating counters (emitted / rejected)
//   dbg_state                  FSM state: 0 = IDLE, 1 = HOLD
//
// Mnemonic codes: 0 NULL, 1 LUI, 2 AUIPC, 3 JAL, 4 JALR, 5 BEQ, 6 BNE, 7 BLT,
//   8 BGE, 9 BLTU, 10 BGEU, 11 LB, 12 LH, 13 LW, 14 LBU, 15 LHU, 16 SB, 17 SH,
//   18 SW, 19 ADDI, 20 SLTI, 21 SLTIU, 22 XORI, 23 ORI, 24 ANDI, 25 SLLI,
//   26 SRLI, 27 SRAI, 28 ADD, 29 SUB, 30 SLL, 31 SLT, 32 SLTU, 33 XOR, 34 SRL,
//   35 SRA, 36 OR, 37 AND, 38 MUL, 39 ECALL, 40 EBREAK; 41..63 are illegal.
module rv32i_instr_encoder #(
  parameter logic [31:0] RESET_BASE = 32'h0000_0000,
  parameter int unsigned CNT_W      = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             s_valid,
  output logic             s_ready,
  input  logic [5:0]       s_mnemonic,
  input  logic [4:0]       s_rs1,
  input  logic [4:0]       s_rs2,
  input  logic [4:0]       s_rd,
  input  logic [31:0]      s_imm,
  input  logic             base_load,
  input  logic [31:0]      base_addr,
  output logic             m_valid,
  input  logic             m_ready,
  output logic [31:0]      m_addr,
  output logic [31:0]      m_data,
  output logic             err_illegal,
  output logic [CNT_W-1:0] word_cnt,
  output logic [CNT_W-1:0] illegal_cnt,
  output logic             dbg_state
);

  typedef enum logic {ST_IDLE = 1'b0, ST_HOLD = 1'b1} state_e;
  typedef enum logic [3:0] {F_NONE, F_R, F_I, F_SH, F_S, F_B, F_U, F_J, F_SYS} fmt_e;

  localparam logic [6:0] OP_LUI = 7'h37, OP_AUIPC = 7'h17, OP_JAL = 7'h6F, OP_JALR = 7'h67;
  localparam logic [6:0] OP_BR = 7'h63, OP_LD = 7'h03, OP_ST = 7'h23, OP_IMM = 7'h13;
  localparam logic [6:0] OP_REG = 7'h33, OP_SYS = 7'h73;
  localparam logic [6:0] F7_ALT = 7'b0100000, F7_MUL = 7'b0000001;

  fmt_e        fmt;
  logic [6:0]  opcode;
  logic [2:0]  funct3;
  logic [6:0]  funct7;
  logic        sys_brk;
  logic [31:0] enc;
  logic        legal;
  logic signed [31:0] simm;

  state_e           state_q, state_d;
  logic [31:0]      wr_ptr_q, ptr_d;
  logic [31:0]      m_addr_q, m_addr_d;
  logic [31:0]      m_data_q, m_data_d;
  logic             err_q, err_d;
  logic [CNT_W-1:0] word_cnt_q, word_cnt_d;
  logic [CNT_W-1:0] illegal_cnt_q, illegal_cnt_d;
  logic             accept, drain;

  // Mnemonic -> instruction format and fixed opcode fields.
  always_comb begin
    fmt = F_NONE; opcode = 7'd0; funct3 = 3'd0; funct7 = 7'd0; sys_brk = 1'b0;
    case (s_mnemonic)
      6'd1:  begin fmt = F_U; opcode = OP_LUI; end
      6'd2:  begin fmt = F_U; opcode = OP_AUIPC; end
      6'd3:  begin fmt = F_J; opcode = OP_JAL; end
      6'd4:  begin fmt = F_I; opcode = OP_JALR; end
      6'd5:  begin fmt = F_B; opcode = OP_BR; funct3 = 3'd0; end
      6'd6:  begin fmt = F_B; opcode = OP_BR; funct3 = 3'd1; end
      6'd7:  begin fmt = F_B; opcode = OP_BR; funct3 = 3'd4; end
      6'd8:  begin fmt = F_B; opcode = OP_BR; funct3 = 3'd5; end
      6'd9:  begin fmt = F_B; opcode = OP_BR; funct3 = 3'd6; end
      6'd10: begin fmt = F_B; opcode = OP_BR; funct3 = 3'd7; end
      6'd11: begin fmt = F_I; opcode = OP_LD; funct3 = 3'd0; end
      6'd12: begin fmt = F_I; opcode = OP_LD; funct3 = 3'd1; end
      6'd13: begin fmt = F_I; opcode = OP_LD; funct3 = 3'd2; end
      6'd14: begin fmt = F_I; opcode = OP_LD; funct3 = 3'd4; end
      6'd15: begin fmt = F_I; opcode = OP_LD; funct3 = 3'd5; end
      6'd16: begin fmt = F_S; opcode = OP_ST; funct3 = 3'd0; end
      6'd17: begin fmt = F_S; opcode = OP_ST; funct3 = 3'd1; end
      6'd18: begin fmt = F_S; opcode = OP_ST; funct3 = 3'd2; end
      6'd19: begin fmt = F_I; opcode = OP_IMM; funct3 = 3'd0; end
      6'd20: begin fmt = F_I; opcode = OP_IMM; funct3 = 3'd2; end
      6'd21: begin fmt = F_I; opcode = OP_IMM; funct3 = 3'd3; end
      6'd22: begin fmt = F_I; opcode = OP_IMM; funct3 = 3'd4; end
      6'd23: begin fmt = F_I; opcode = OP_IMM; funct3 = 3'd6; end
      6'd24: begin fmt = F_I; opcode = OP_IMM; funct3 = 3'd7; end
      6'd25: begin fmt = F_SH; opcode = OP_IMM; funct3 = 3'd1; end
      6'd26: begin fmt = F_SH; opcode = OP_IMM; funct3 = 3'd5; end
      6'd27: begin fmt = F_SH; opcode = OP_IMM; funct3 = 3'd5; funct7 = F7_ALT; end
      6'd28: begin fmt = F_R; opcode = OP_REG; funct3 = 3'd0; end
      6'd29: begin fmt = F_R; opcode = OP_REG; funct3 = 3'd0; funct7 = F7_ALT; end
      6'd30: begin fmt = F_R; opcode = OP_REG; funct3 = 3'd1; end
      6'd31: begin fmt = F_R; opcode = OP_REG; funct3 = 3'd2; end
      6'd32: begin fmt = F_R; opcode = OP_REG; funct3 = 3'd3; end
      6'd33: begin fmt = F_R; opcode = OP_REG; funct3 = 3'd4; end
      6'd34: begin fmt = F_R; opcode = OP_REG; funct3 = 3'd5; end
      6'd35: begin fmt = F_R; opcode = OP_REG; funct3 = 3'd5; funct7 = F7_ALT; end
      6'd36: begin fmt = F_R; opcode = OP_REG; funct3 = 3'd6; end
      6'd37: begin fmt = F_R; opcode = OP_REG; funct3 = 3'd7; end
      6'd38: begin fmt = F_R; opcode = OP_REG; funct3 = 3'd0; funct7 = F7_MUL; end
      6'd39: begin fmt = F_SYS; end
      6'd40: begin fmt = F_SYS; sys_brk = 1'b1; end
      default: ;
    endcase
  end

  // Field placement and immediate range checks.
  always_comb begin
    enc   = 32'd0;
    legal = 1'b0;
    simm  = $signed(s_imm);
    case (fmt)
      F_R: begin
        enc   = {funct7, s_rs2, s_rs1, funct3, s_rd, opcode};
        legal = 1'b1;
      end
      F_I: begin
        enc   = {s_imm[11:0], s_rs1, funct3, s_rd, opcode};
        legal = (simm >= -32'sd2048) && (simm <= 32'sd2047);
      end
      F_SH: begin
        enc   = {funct7, s_imm[4:0], s_rs1, funct3, s_rd, opcode};
        legal = (s_imm[31:5] == 27'd0);  // shamt treated as unsigned
      end
      F_S: begin
        enc   = {s_imm[11:5], s_rs2, s_rs1, funct3, s_imm[4:0], opcode};
        legal = (simm >= -32'sd2048) && (simm <= 32'sd2047);
      end
      F_B: begin
        enc   = {s_imm[12], s_imm[10:5], s_rs2, s_rs1, funct3, s_imm[4:1], s_imm[11], opcode};
        legal = !s_imm[0] && (simm >= -32'sd4096) && (simm <= 32'sd4094);
      end
      F_U: begin
        enc   = {s_imm[31:12], s_rd, opcode};
        legal = (s_imm[11:0] == 12'd0);
      end
      F_J: begin
        enc   = {s_imm[20], s_imm[10:1], s_imm[11], s_imm[19:12], s_rd, opcode};
        legal = !s_imm[0] && (simm >= -32'sd1048576) && (simm <= 32'sd1048574);
      end
      F_SYS: begin
        enc   = {11'd0, sys_brk, 13'd0, OP_SYS};
        legal = 1'b1;
      end
      default: ;
    endcase
  end

  // Control: a drain and a new legal accept may coincide; the new word then
  // takes the already-advanced pointer so back-to-back words are contiguous.
  always_comb begin
    s_ready = (state_q == ST_IDLE) || m_ready;
    accept  = s_valid && s_ready;
    drain   = (state_q == ST_HOLD) && m_ready;

    ptr_d = wr_ptr_q;
    if (drain) ptr_d = wr_ptr_q + 32'd4;
    else if ((state_q == ST_IDLE) && base_load) ptr_d = {base_addr[31:2], 2'b00};

    state_d  = state_q;
    m_addr_d = m_addr_q;
    m_data_d = m_data_q;
    if (accept && legal) begin
      state_d  = ST_HOLD;
      m_addr_d = ptr_d;
      m_data_d = enc;
    end else if (drain) begin
      state_d = ST_IDLE;
    end

    err_d = accept && !legal;

    word_cnt_d = word_cnt_q;
    if (drain && !(&word_cnt_q)) word_cnt_d = word_cnt_q + CNT_W'(1);
    illegal_cnt_d = illegal_cnt_q;
    if (err_d && !(&illegal_cnt_q)) illegal_cnt_d = illegal_cnt_q + CNT_W'(1);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q       <= ST_IDLE;
      wr_ptr_q      <= RESET_BASE;
      m_addr_q      <= 32'd0;
      m_data_q      <= 32'd0;
      err_q         <= 1'b0;
      word_cnt_q    <= '0;
      illegal_cnt_q <= '0;
    end else begin
      state_q       <= state_d;
      wr_ptr_q      <= ptr_d;
      m_addr_q      <= m_addr_d;
      m_data_q      <= m_data_d;
      err_q         <= err_d;
      word_cnt_q    <= word_cnt_d;
      illegal_cnt_q <= illegal_cnt_d;
    end
  end

  assign m_valid     = (state_q == ST_HOLD);
  assign m_addr      = m_addr_q;
  assign m_data      = m_data_q;
  assign err_illegal = err_q;
  assign word_cnt    = word_cnt_q;
  assign illegal_cnt = illegal_cnt_q;
  assign dbg_state   = (state_q == ST_HOLD);

endmodule

// File: tb/tb_rv32i_instr_encoder.sv
module tb_rv32i_instr_encoder;

  localparam logic [31:0] RB = 32'h0000_1000;
  localparam int CW = 4;
  localparam int CMAX = (1 << CW) - 1;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  logic          s_valid = 1'b0;
  logic          s_ready;
  logic [5:0]    s_mnemonic = 6'd0;
  logic [4:0]    s_rs1 = 5'd0, s_rs2 = 5'd0, s_rd = 5'd0;
  logic [31:0]   s_imm = 32'd0;
  logic          base_load = 1'b0;
  logic [31:0]   base_addr = 32'd0;
  logic          m_valid;
  logic          m_ready = 1'b0;
  logic [31:0]   m_addr, m_data;
  logic          err_illegal;
  logic [CW-1:0] word_cnt, illegal_cnt;
  logic          dbg_state;

  rv32i_instr_encoder #(.RESET_BASE(RB), .CNT_W(CW)) dut (
    .clk(clk), .rst_n(rst_n), .s_valid(s_valid), .s_ready(s_ready),
    .s_mnemonic(s_mnemonic), .s_rs1(s_rs1), .s_rs2(s_rs2), .s_rd(s_rd), .s_imm(s_imm),
    .base_load(base_load), .base_addr(base_addr), .m_valid(m_valid), .m_ready(m_ready),
    .m_addr(m_addr), .m_data(m_data), .err_illegal(err_illegal),
    .word_cnt(word_cnt), .illegal_cnt(illegal_cnt), .dbg_state(dbg_state)
  );

  int n_checks = 0;
  int n_fail = 0;

  task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  // ---------------- reference model ----------------
  int br_f3[6]  = '{0, 1, 4, 5, 6, 7};
  int ld_f3[5]  = '{0, 1, 2, 4, 5};
  int ai_f3[6]  = '{0, 2, 3, 4, 6, 7};
  int r_f3[10]  = '{0, 0, 1, 2, 3, 4, 5, 5, 6, 7};

  function automatic int place_i(int imm, int r1, int f3, int d, int op);
    return ((imm & 'hFFF) << 20) | (r1 << 15) | (f3 << 12) | (d << 7) | op;
  endfunction

  function automatic int place_r(int f7, int r2, int r1, int f3, int d, int op);
    return (f7 << 25) | (r2 << 20) | (r1 << 15) | (f3 << 12) | (d << 7) | op;
  endfunction

  function automatic logic [31:0] ref_encode(input int mn, input int r1, input int r2,
                                             input int d, input logic [31:0] imm,
                                             output bit legal);
    int si;
    int w;
    si = imm;
    w = 0;
    legal = 1'b1;
    if (mn == 1 || mn == 2) begin
      legal = (imm % 4096) == 0;
      w = int'(imm & 32'hFFFF_F000) | (d << 7) | ((mn == 1) ? 'h37 : 'h17);
    end else if (mn == 3) begin
      legal = (si % 2 == 0) && si >= -1048576 && si <= 1048574;
      w = (((si >> 20) & 1) << 31) | (((si >> 1) & 1023) << 21) | (((si >> 11) & 1) << 20) |
          (((si >> 12) & 255) << 12) | (d << 7) | 'h6F;
    end else if (mn == 4 || (mn >= 11 && mn <= 15) || (mn >= 19 && mn <= 24)) begin
      legal = si >= -2048 && si <= 2047;
      if (mn == 4)       w = place_i(si, r1, 0, d, 'h67);
      else if (mn <= 15) w = place_i(si, r1, ld_f3[mn-11], d, 'h03);
      else               w = place_i(si, r1, ai_f3[mn-19], d, 'h13);
    end else if (mn >= 5 && mn <= 10) begin
      legal = (si % 2 == 0) && si >= -4096 && si <= 4094;
      w = (((si >> 12) & 1) << 31) | (((si >> 5) & 63) << 25) | (r2 << 20) | (r1 << 15) |
          (br_f3[mn-5] << 12) | (((si >> 1) & 15) << 8) | (((si >> 11) & 1) << 7) | 'h63;
    end else if (mn >= 16 && mn <= 18) begin
      legal = si >= -2048 && si <= 2047;
      w = (((si >> 5) & 'h7F) << 25) | (r2 << 20) | (r1 << 15) | ((mn - 16) << 12) |
          ((si & 31) << 7) | 'h23;
    end else if (mn >= 25 && mn <= 27) begin
      legal = imm < 32;
      w = place_r((mn == 27) ? 'h20 : 0, si & 31, r1, (mn == 25) ? 1 : 5, d, 'h13);
    end else if (mn >= 28 && mn <= 37) begin
      w = place_r((mn == 29 || mn == 35) ? 'h20 : 0, r2, r1, r_f3[mn-28], d, 'h33);
    end else if (mn == 38) begin
      w = place_r(1, r2, r1, 0, d, 'h33);
    end else if (mn == 39) begin
      w = 'h73;
    end else if (mn == 40) begin
      w = 'h0010_0073;
    end else begin
      legal = 1'b0;
    end
    return w;
  endfunction

  // ---------------- scoreboard ----------------
  // Expected queue of {addr, data}; front entry is the word that must be on
  // the output. Model state advances at each negedge for the coming posedge.
  logic [63:0] exp_q[$];
  logic [31:0] mdl_ptr = RB;
  bit          mdl_err = 1'b0;
  int          mdl_wcnt = 0;
  int          mdl_icnt = 0;

  always @(negedge clk) begin
    bit full, drain, acc, lg, err_n;
    logic [31:0] ptr_n, w;
    if (!rst_n) begin
      exp_q.delete();
      mdl_ptr = RB; mdl_err = 1'b0; mdl_wcnt = 0; mdl_icnt = 0;
    end else begin
      full = exp_q.size() != 0;
      check_eq("m_valid", m_valid, full);
      check_eq("dbg_state", dbg_state, full);
      check_eq("s_ready", s_ready, !full || m_ready);
      check_eq("err_illegal", err_illegal, mdl_err);
      check_eq("word_cnt", word_cnt, mdl_wcnt);
      check_eq("illegal_cnt", illegal_cnt, mdl_icnt);
      if (full) check_eq("m_addr_data", {m_addr, m_data}, exp_q[0]);

      drain = full && m_ready;
      ptr_n = mdl_ptr;
      if (drain) ptr_n = mdl_ptr + 32'd4;
      else if (!full && base_load) ptr_n = base_addr & 32'hFFFF_FFFC;
      acc = s_valid && (!full || m_ready);
      err_n = 1'b0;
      if (drain) begin
        void'(exp_q.pop_front());
        if (mdl_wcnt < CMAX) mdl_wcnt++;
      end
      if (acc) begin
        w = ref_encode(int'(s_mnemonic), int'(s_rs1), int'(s_rs2), int'(s_rd), s_imm, lg);
        if (lg) exp_q.push_back({ptr_n, w});
        else begin
          err_n = 1'b1;
          if (mdl_icnt < CMAX) mdl_icnt++;
        end
      end
      mdl_ptr = ptr_n;
      mdl_err = err_n;
    end
  end

  // ---------------- driver tasks ----------------
  // Called at posedge+1; returns at posedge+1 right after the accepting edge.
  task automatic send(input int mn, input int r1, input int r2, input int d,
                      input logic [31:0] imm);
    int budget;
    bit ok;
    budget = 0;
    ok = 1'b0;
    s_valid = 1'b1; s_mnemonic = 6'(mn);
    s_rs1 = 5'(r1); s_rs2 = 5'(r2); s_rd = 5'(d); s_imm = imm;
    while (!ok && budget < 60) begin
      @(negedge clk);
      ok = s_ready;
      budget++;
    end
    if (!ok) check_eq("send_timeout", 1'b0, 1'b1);
    @(posedge clk); #1;
    s_valid = 1'b0;
  endtask

  task automatic wait_idle();
    bit ok;
    ok = 1'b0;
    m_ready = 1'b1;
    for (int i = 0; i < 20 && !ok; i++) begin
      @(negedge clk);
      ok = !m_valid;
    end
    if (!ok) check_eq("drain_timeout", 1'b0, 1'b1);
    @(posedge clk); #1;
  endtask

  int edge_vals[25] = '{-4097, -4096, -4095, -2049, -2048, -2047, 2046, 2047, 2048,
                        4094, 4095, 4096, 31, 32, 0, 1, -1, 1048574, 1048575, 1048576,
                        -1048576, -1048577, -1048578, 'h1000, 'h7FFF_F000};

  function automatic logic [31:0] pick_imm();
    case ($urandom_range(0, 5))
      0: return 32'($urandom_range(0, 40)) - 32'd20;
      1: return $urandom;
      2: return {20'($urandom_range(0, 20'hFFFFF)), 12'h000};
      default: return edge_vals[$urandom_range(0, 24)];
    endcase
  endfunction

  // ---------------- stimulus ----------------
  bit done = 1'b0;

  initial begin
    repeat (3) @(posedge clk);
    #1;
    check_eq("rst_m_valid", m_valid, 1'b0);
    check_eq("rst_m_data", m_data, 32'd0);
    check_eq("rst_m_addr", m_addr, 32'd0);
    check_eq("rst_err", err_illegal, 1'b0);
    check_eq("rst_word_cnt", word_cnt, 0);
    check_eq("rst_illegal_cnt", illegal_cnt, 0);
    check_eq("rst_s_ready", s_ready, 1'b1);
    check_eq("rst_state", dbg_state, 1'b0);
    rst_n = 1'b1;

    // ADDI x1, x0, 5
    m_ready = 1'b1;
    send(19, 0, 0, 1, 32'd5);
    check_eq("addi_data", m_data, 32'h0050_0093);
    check_eq("addi_addr", m_addr, RB);
    @(posedge clk); #1;
    check_eq("addi_word_cnt", word_cnt, 1);

    // SUB x3,x1,x2 then BEQ x1,x2,+8 with output stalled
    m_ready = 1'b0;
    send(29, 1, 2, 3, 32'd0);
    fork
      send(5, 1, 2, 0, 32'd8);
      begin
        repeat (3) begin
          check_eq("stall_data", m_data, 32'h4020_81B3);
          check_eq("stall_addr", m_addr, RB + 32'd4);
          check_eq("stall_s_ready", s_ready, 1'b0);
          @(posedge clk); #1;
        end
        m_ready = 1'b1;
      end
    join
    check_eq("beq_data", m_data, 32'h0020_8463);
    check_eq("beq_addr", m_addr, RB + 32'd8);
    wait_idle();

    // Illegal requests
    send(19, 0, 0, 1, 32'd4096);
    check_eq("ill1_pulse", err_illegal, 1'b1);
    send(25, 0, 0, 1, 32'd32);
    check_eq("ill2_pulse", err_illegal, 1'b1);
    send(0, 0, 0, 0, 32'd0);
    check_eq("ill3_pulse", err_illegal, 1'b1);
    check_eq("ill_cnt3", illegal_cnt, 3);
    check_eq("ill_no_valid", m_valid, 1'b0);
    send(19, 2, 0, 4, 32'hFFFF_F800);
    check_eq("ptr_unchanged", m_addr, RB + 32'd12);
    wait_idle();

    // Pointer reload and wrap
    base_load = 1'b1; base_addr = 32'hFFFF_FFFE;
    @(posedge clk); #1;
    base_load = 1'b0;
    send(28, 1, 2, 3, 32'd0);
    check_eq("wrap_addr0", m_addr, 32'hFFFF_FFFC);
    send(1, 0, 0, 5, 32'hABCD_E000);
    check_eq("wrap_addr1", m_addr, 32'h0000_0000);
    send(40, 0, 0, 0, 32'd0);
    check_eq("wrap_addr2", m_addr, 32'h0000_0004);
    check_eq("ebreak_data", m_data, 32'h0010_0073);
    wait_idle();

    // Reset while holding a word
    m_ready = 1'b0;
    send(3, 0, 0, 1, 32'd2048);
    @(negedge clk); #2;
    rst_n = 1'b0;
    #1;
    check_eq("async_m_valid", m_valid, 1'b0);
    check_eq("async_m_data", m_data, 32'd0);
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1'b1;
    m_ready = 1'b1;
    check_eq("post_rst_ready", s_ready, 1'b1);
    send(39, 0, 0, 0, 32'd0);
    check_eq("post_rst_addr", m_addr, RB);
    check_eq("ecall_data", m_data, 32'h0000_0073);
    @(posedge clk); #1;
    check_eq("post_rst_word_cnt", word_cnt, 1);

    // Counter saturation on rejects
    for (int i = 0; i < CMAX + 2; i++) send(41 + (i % 20), 0, 0, 0, 32'd0);
    check_eq("illegal_cnt_sat", illegal_cnt, CMAX);

    // Randomized traffic
    fork
      begin
        for (int k = 0; k < 400; k++) begin
          if ($urandom_range(0, 3) == 0) begin @(posedge clk); #1; end
          send($urandom_range(0, 44), $urandom_range(0, 31), $urandom_range(0, 31),
               $urandom_range(0, 31), pick_imm());
        end
        done = 1'b1;
      end
      begin
        while (!done) begin
          @(posedge clk); #1;
          m_ready   = $urandom_range(0, 3) != 0;
          base_load = $urandom_range(0, 9) == 0;
          base_addr = $urandom;
        end
      end
    join
    base_load = 1'b0;
    wait_idle();
    check_eq("word_cnt_sat", word_cnt, CMAX);
    check_eq("queue_empty", exp_q.size(), 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog expired");
  end

endmodule
